multdiv_unit: RTL

Multicycle signed 32-bit multiply/divide unit next to the execute stage of the pipelined processor. Execute forwards operands and a one-cycle start strobe when it decodes a MUL/DIV ALU op. The unit iterates for a fixed number of cycles and returns a registered result with a one-cycle ready pulse. Execute holds the pipeline stalled on `busy` and writes back `data_result` on `data_resultRDY`.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_unit_div_step.sv | 27 ++
 rtl/multdiv_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit and the execute-stage decoder.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_e;

  localparam int unsigned MD_ITER = 32;
  localparam int unsigned CNT_W   = 6;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted - {1'b0, div_i};
    rem_o   = shifted[W-1:0];
    quo_o   = {quo_i[W-2:0], 1'b0};
    // Remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with registered result and ready pulse.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned WW = AW + WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Accumulator is one bit wider than the operands so subtracting the most negative multiplicand cannot wrap.
  logic [WW-1:0]    work_q, work_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [AW-1:0]    acc, sum;
  logic [WW-1:0]    booth_tmp;
  logic [AW-1:0]    prod_hi;
  logic [WIDTH-1:0] a_abs, b_abs, quo;

  div_step #(.W(WIDTH)) u_div_step (
    .rem_i (work_q[WW-2 -: WIDTH]),
    .quo_i (work_q[WIDTH:1]),
    .div_i (mcand_q[WIDTH-1:0]),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    exc_d     = exc_q;

    a_abs     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_abs     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    acc       = work_q[WW-1 -: AW];
    sum       = acc;
    booth_tmp = work_q;
    prod_hi   = work_q[2*WIDTH:WIDTH];
    quo       = neg_q ? -work_q[WIDTH:1] : work_q[WIDTH:1];

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT ^ ctrl_DIV) begin
          cnt_d = '0;
          if (ctrl_MULT) begin
            state_d = ST_MUL;
            work_d  = {{AW{1'b0}}, data_operandB, 1'b0};
            mcand_d = {data_operandA[WIDTH-1], data_operandA};
          end else begin
            state_d = ST_DIV;
            work_d  = {{AW{1'b0}}, a_abs, 1'b0};
            mcand_d = {1'b0, b_abs};
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf_d   = (data_operandA == MIN_NEG) && (data_operandB == '1);
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(MD_ITER)) begin
          state_d  = ST_DONE;
          result_d = work_q[WIDTH:1];
          exc_d    = !((&prod_hi) || !(|prod_hi));
        end else begin
          unique case ({work_q[1], work_q[0]})
            2'b01:   sum = acc + mcand_q;
            2'b10:   sum = acc - mcand_q;
            default: sum = acc;
          endcase
          booth_tmp = {sum, work_q[WIDTH:0]};
          work_d    = {booth_tmp[WW-1], booth_tmp[WW-1:1]};
          cnt_d     = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (mcand_q == '0) begin
          state_d  = ST_DONE;
          result_d = '0;
          exc_d    = 1'b1;
        end else if (cnt_q == CNT_W'(MD_ITER)) begin
          state_d  = ST_DONE;
          result_d = quo;
          exc_d    = ovf_q;
        end else begin
          work_d = {1'b0, rem_nxt, quo_nxt, 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign data_resultRDY = (state_q == ST_DONE);
  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule
